// File: rtl/serial_sub.sv
// Bit-serial subtractor: one full-subtractor slice per clock, LSB first,
// with the borrow carried between cycles in a single flop.
//
// state | meaning
// IDLE  | waiting for start; operands latched on acceptance
// SHIFT | one bit slice per cycle, WIDTH cycles total
// DONE  | diff/borrow just loaded, done pulses, back to IDLE next cycle
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, res;
  logic [CW-1:0]    cnt;
  logic             brw;
  logic             ai, bi, d, bout;

  assign ai   = a_sr[0];
  assign bi   = b_sr[0];
  assign d    = ai ^ bi ^ brw;
  assign bout = (~ai & bi) | (~(ai ^ bi) & brw);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Decoded from the state flop only, so start never reaches these combinationally.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      SHIFT:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res    <= '0;
      cnt    <= '0;
      brw    <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr <= a;
            b_sr <= b;
            brw  <= 1'b0;
            cnt  <= '0;
          end
        end
        SHIFT: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          res  <= {d, res[WIDTH-1:1]};
          brw  <= bout;
          cnt  <= cnt + 1'b1;
          // Final slice goes straight into diff so no partial value is ever visible.
          if (cnt == LAST) begin
            diff   <= {d, res[WIDTH-1:1]};
            borrow <= bout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
